// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable word length, parity and stop bits.
// Held word plus error flags are presented on a data_ready / data_ack handshake.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  input  logic [1:0]           parity_mode,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TC   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC   = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_flag_q, par_flag_d;
  logic                   stop_flag_q, stop_flag_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_ready_q, data_ready_d;
  logic                   perr_q, perr_d;
  logic                   serr_q, serr_d;
  logic                   ovr_q, ovr_d;
  logic                   mid_bit;
  logic                   parity_on;

  always_comb begin
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    par_flag_d   = par_flag_q;
    stop_flag_d  = stop_flag_q;
    done_d       = 1'b0;
    data_out_d   = data_out_q;
    data_ready_d = data_ready_q;
    perr_d       = perr_q;
    serr_d       = serr_q;
    ovr_d        = ovr_q;
    mid_bit      = sample_tick && (cnt_q == FULL_TC);
    parity_on    = mode_q[0] ^ mode_q[1];

    if (sample_tick && state_q != S_IDLE && !mid_bit) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (rx_en && armed_q) begin
            state_d = S_START;
            armed_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_START: begin
        // The start bit is confirmed half a bit after the falling edge.
        if (sample_tick && cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d     = S_DATA;
            bit_idx_d   = '0;
            mode_d      = parity_mode;
            shift_d     = '0;
            par_flag_d  = 1'b0;
            stop_flag_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_idx_q == 4'(i)) shift_d[i] = rx_s_q;
          end
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = parity_on ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid_bit) begin
          cnt_d      = '0;
          par_flag_d = rx_s_q != ((^shift_q) ^ mode_q[1]);
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (mid_bit) begin
          cnt_d = '0;
          if (!rx_s_q) stop_flag_d = 1'b1;
          if (bit_idx_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping the enable discards any partial frame.
    if (state_q != S_IDLE && !rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    if (done_q) begin
      data_out_d   = shift_q;
      perr_d       = par_flag_q;
      serr_d       = stop_flag_q;
      data_ready_d = 1'b1;
      if (data_ready_q && !data_ack) ovr_d = 1'b1;
    end else if (data_ack && data_ready_q) begin
      data_ready_d = 1'b0;
      ovr_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      mode_q       <= '0;
      shift_q      <= '0;
      par_flag_q   <= 1'b0;
      stop_flag_q  <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      perr_q       <= 1'b0;
      serr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      par_flag_q   <= par_flag_d;
      stop_flag_q  <= stop_flag_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_ready    = data_ready_q;
  assign parity_error  = perr_q;
  assign stop_error    = serr_q;
  assign overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboarded bench for uart_rx_cfg: frames are serialised from tick counts,
// expected words come from a parity/stop/overrun model and are matched by a monitor.
module tb_uart_rx_cfg;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_en;
  logic          sample_tick;
  logic [1:0]    parity_mode;
  logic          rx;
  logic          data_ack;
  logic [DB-1:0] data_out;
  logic          data_ready;
  logic          parity_error;
  logic          stop_error;
  logic          overrun_error;

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_en         (rx_en),
    .sample_tick   (sample_tick),
    .parity_mode   (parity_mode),
    .rx            (rx),
    .data_ack      (data_ack),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .parity_error  (parity_error),
    .stop_error    (stop_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = ($urandom_range(0, 2) != 0);
    end
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          serr;
    logic          ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   m_ready = 1'b0;
  bit   m_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int clks = 0;
    while (seen < n && clks < n * 40 + 10) begin
      @(posedge clk);
      clks++;
      if (sample_tick) seen++;
    end
    if (seen < n) check("tick_budget", seen, n);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_ticks(n);
  endtask

  // Reference: parity judged by total count of ones, overrun by pending-word state.
  task automatic model_frame(input logic [DB-1:0] d, input logic [1:0] mode,
                             input logic pbit, input logic sbit);
    exp_t e;
    int   ones = $countones(d) + int'(pbit);
    e.data = d;
    if (mode == 2'b01)      e.perr = (ones % 2) != 0;
    else if (mode == 2'b10) e.perr = (ones % 2) != 1;
    else                    e.perr = 1'b0;
    e.serr  = !sbit;
    e.ovr   = m_ovr | m_ready;
    m_ovr   = e.ovr;
    m_ready = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] mode,
                            input logic pbit, input logic sbit);
    parity_mode = mode;
    model_frame(d, mode, pbit, sbit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      rx = pbit;
      wait_ticks(OS);
    end
    rx = sbit;
    wait_ticks(OS);
  endtask

  function automatic logic good_parity(input logic [DB-1:0] d, input logic [1:0] mode);
    return logic'(($countones(d) + (mode == 2'b10 ? 1 : 0)) % 2);
  endfunction

  task automatic ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    m_ready  = 1'b0;
    m_ovr    = 1'b0;
    check("ack_ready", data_ready, m_ready);
    check("ack_overrun", overrun_error, m_ovr);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_ready"}, data_ready, 0);
    check({tag, "_perr"}, parity_error, 0);
    check({tag, "_serr"}, stop_error, 0);
    check({tag, "_ovr"}, overrun_error, 0);
  endtask

  // Monitor: a new word shows as data_ready rising, or a changed word / new overrun while held.
  initial begin
    logic          p_rdy = 1'b0;
    logic          p_ovr = 1'b0;
    logic [DB-1:0] p_out = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!reset && data_ready &&
          (!p_rdy || data_out != p_out || (overrun_error && !p_ovr))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", data_out, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", data_out, e.data);
          check("frame_perr", parity_error, e.perr);
          check("frame_serr", stop_error, e.serr);
          check("frame_ovr", overrun_error, e.ovr);
        end
      end
      p_rdy = data_ready;
      p_ovr = overrun_error;
      p_out = data_out;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] d;
    logic [1:0]    mode;
    logic          pbit;
    logic          sbit;

    reset = 1'b1; rx = 1'b1; rx_en = 1'b1; data_ack = 1'b0; parity_mode = 2'b00;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    idle(20);

    send_frame(8'hA5, 2'b01, 1'b0, 1'b1);
    ack();

    send_frame(8'h3C, 2'b10, 1'b0, 1'b1);
    ack();
    check("perr_held", parity_error, 1);
    send_frame(8'h3C, 2'b10, 1'b1, 1'b1);
    ack();
    check("perr_cleared", parity_error, 0);

    // Break: stop bit low, then line kept low for three frame times.
    send_frame(8'h55, 2'b00, 1'b0, 1'b0);
    wait_ticks(OS * 2);
    ack();
    check("serr_held", stop_error, 1);
    wait_ticks(OS * 30);
    check("break_no_word", data_ready, 0);
    idle(OS);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    ack();
    check("serr_cleared", stop_error, 0);

    rx = 1'b0;
    wait_ticks(4);
    idle(OS * 4);
    check("glitch_no_word", data_ready, 0);

    send_frame(8'h11, 2'b00, 1'b0, 1'b1);
    idle(4);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1);
    check("overrun_set", overrun_error, 1);
    check("overrun_data", data_out, 8'h22);
    ack();

    // Reset while bits of a second frame are arriving, with a word still unread.
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1);
    idle(4);
    rx = 1'b0; wait_ticks(OS);
    rx = 1'b1; wait_ticks(OS);
    rx = 1'b0; wait_ticks(OS);
    rx = 1'b1; wait_ticks(OS / 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    check_cleared("midreset");
    idle(OS * 2);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    ack();

    rx = 1'b0; wait_ticks(OS);
    rx = 1'b1; wait_ticks(OS);
    rx = 1'b0; wait_ticks(OS / 2);
    rx_en = 1'b0;
    @(negedge clk);
    rx_en = 1'b1;
    idle(OS * 12);
    check("abort_no_word", data_ready, 0);
    send_frame(8'hC3, 2'b01, 1'b0, 1'b1);
    ack();

    for (int k = 0; k < 20; k++) begin
      d    = DB'($urandom);
      mode = 2'($urandom_range(0, 3));
      pbit = good_parity(d, mode) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 4) != 0);
      send_frame(d, mode, pbit, sbit);
      if (!sbit) idle(OS);
      ack();
      idle($urandom_range(2, 20));
    end

    idle(OS * 2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
